vld_st_drain_ctrl: RTL

// - Head-side consumer of the vector load/store buffer.
// - Inspects the buffer head. If its block is not yet fetched, requests the block from memory
//   and returns the fill notification (update port) to the buffer.
// - Once the head is fetched, performs the cache read/write, returns load data with its ROB

---
 rtl/vld_st_drain_ctrl_if.sv | 67 ++++++
 rtl/vld_st_drain_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vld_st_drain_ctrl_if.sv
// Signal bundle between the vector load/store buffer head, memory and cache and the drain controller.
// master = drain controller, slave = buffer/memory/cache side.
interface vld_st_drain_ctrl_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_BITS     = 32,
  parameter int unsigned MICROOP_WIDTH = 7,
  parameter int unsigned TICKET_WIDTH  = 4,
  parameter int unsigned SIZE_WIDTH    = 3
) ();

  // buffer head
  logic                     buf_valid_i;
  logic                     head_is_store_i;
  logic                     head_is_fetched_i;
  logic [ADDR_BITS-1:0]     head_address_i;
  logic [DATA_WIDTH-1:0]    head_data_i;
  logic [MICROOP_WIDTH-1:0] head_microop_i;
  logic [TICKET_WIDTH-1:0]  head_ticket_i;
  logic [SIZE_WIDTH-1:0]    head_size_i;
  logic                     pop_o;
  logic                     update_valid_o;
  logic [ADDR_BITS-1:0]     update_address_o;

  // memory block fetch
  logic                     mem_req_valid_o;
  logic                     mem_req_ready_i;
  logic [ADDR_BITS-1:0]     mem_req_address_o;
  logic                     mem_resp_valid_i;

  // cache access
  logic                     cache_valid_o;
  logic                     cache_ready_i;
  logic                     cache_write_o;
  logic [ADDR_BITS-1:0]     cache_address_o;
  logic [DATA_WIDTH-1:0]    cache_wdata_o;
  logic [SIZE_WIDTH-1:0]    cache_size_o;
  logic                     cache_rvalid_i;
  logic [DATA_WIDTH-1:0]    cache_rdata_i;

  // load writeback and status
  logic                     wb_valid_o;
  logic [TICKET_WIDTH-1:0]  wb_ticket_o;
  logic [MICROOP_WIDTH-1:0] wb_microop_o;
  logic [DATA_WIDTH-1:0]    wb_data_o;
  logic                     err_timeout_o;

  modport master (
    input  buf_valid_i, head_is_store_i, head_is_fetched_i, head_address_i,
           head_data_i, head_microop_i, head_ticket_i, head_size_i,
           mem_req_ready_i, mem_resp_valid_i, cache_ready_i, cache_rvalid_i, cache_rdata_i,
    output pop_o, update_valid_o, update_address_o,
           mem_req_valid_o, mem_req_address_o,
           cache_valid_o, cache_write_o, cache_address_o, cache_wdata_o, cache_size_o,
           wb_valid_o, wb_ticket_o, wb_microop_o, wb_data_o, err_timeout_o
  );

  modport slave (
    output buf_valid_i, head_is_store_i, head_is_fetched_i, head_address_i,
           head_data_i, head_microop_i, head_ticket_i, head_size_i,
           mem_req_ready_i, mem_resp_valid_i, cache_ready_i, cache_rvalid_i, cache_rdata_i,
    input  pop_o, update_valid_o, update_address_o,
           mem_req_valid_o, mem_req_address_o,
           cache_valid_o, cache_write_o, cache_address_o, cache_wdata_o, cache_size_o,
           wb_valid_o, wb_ticket_o, wb_microop_o, wb_data_o, err_timeout_o
  );

endinterface

// File: rtl/vld_st_drain_ctrl.sv
// Head-side drain controller for the vector load/store buffer: fetches missing blocks, then
// performs the cache access and pops in order. Define VLDST_DRAIN_TIMEOUT_EN for the WAIT watchdog.
module vld_st_drain_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned BLOCK_ID_START = 5,
  parameter int unsigned MICROOP_WIDTH  = 7,
  parameter int unsigned TICKET_WIDTH   = 4,
  parameter int unsigned SIZE_WIDTH     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  vld_st_drain_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_ACCESS  = 3'd3,
    S_LD_WAIT = 3'd4
  } state_t;

  state_t                   state;
  logic                     mem_req_q;
  logic                     cache_req_q;
  logic                     lat_is_store;
  logic [ADDR_BITS-1:0]     lat_address;
  logic [DATA_WIDTH-1:0]    lat_data;
  logic [MICROOP_WIDTH-1:0] lat_microop;
  logic [TICKET_WIDTH-1:0]  lat_ticket;
  logic [SIZE_WIDTH-1:0]    lat_size;

  logic [ADDR_BITS-1:0]     blk_address;
  logic                     fill_done;
  logic                     st_done;
  logic                     ld_done;
  logic                     tmo_fire;

  assign blk_address = {lat_address[ADDR_BITS-1:BLOCK_ID_START], {BLOCK_ID_START{1'b0}}};

  // Handshake completions that must be answered in the same cycle they occur
  assign fill_done = (state == S_WAIT)    && bus.mem_resp_valid_i;
  assign st_done   = (state == S_ACCESS)  && bus.cache_ready_i && lat_is_store;
  assign ld_done   = (state == S_LD_WAIT) && bus.cache_rvalid_i;

`ifdef VLDST_DRAIN_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign tmo_fire = (state == S_WAIT) && !bus.mem_resp_valid_i &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counter is held at zero outside WAIT, so every WAIT entry starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != S_WAIT || tmo_fire) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err_timeout_o = err_q;
`else
  wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);

  assign tmo_fire          = 1'b0;
  assign bus.err_timeout_o = 1'b0;
`endif

  // Control FSM; request strobes are registered alongside the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mem_req_q    <= 1'b0;
      cache_req_q  <= 1'b0;
      lat_is_store <= 1'b0;
      lat_address  <= '0;
      lat_data     <= '0;
      lat_microop  <= '0;
      lat_ticket   <= '0;
      lat_size     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.buf_valid_i) begin
            lat_is_store <= bus.head_is_store_i;
            lat_address  <= bus.head_address_i;
            lat_data     <= bus.head_data_i;
            lat_microop  <= bus.head_microop_i;
            lat_ticket   <= bus.head_ticket_i;
            lat_size     <= bus.head_size_i;
            if (bus.head_is_fetched_i) begin
              state       <= S_ACCESS;
              cache_req_q <= 1'b1;
            end else begin
              state     <= S_REQ;
              mem_req_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready_i) begin
            state     <= S_WAIT;
            mem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          // A late head_is_fetched_i is ignored here; the fill always completes
          if (fill_done) begin
            state <= S_IDLE;
          end else if (tmo_fire) begin
            state     <= S_REQ;
            mem_req_q <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (bus.cache_ready_i) begin
            cache_req_q <= 1'b0;
            state       <= lat_is_store ? S_IDLE : S_LD_WAIT;
          end
        end
        S_LD_WAIT: begin
          if (bus.cache_rvalid_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          mem_req_q   <= 1'b0;
          cache_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pop_o             = (st_done || ld_done) && bus.buf_valid_i;
  assign bus.update_valid_o    = fill_done;
  assign bus.update_address_o  = blk_address;

  assign bus.mem_req_valid_o   = mem_req_q;
  assign bus.mem_req_address_o = blk_address;

  assign bus.cache_valid_o     = cache_req_q;
  assign bus.cache_write_o     = lat_is_store;
  assign bus.cache_address_o   = lat_address;
  assign bus.cache_wdata_o     = lat_data;
  assign bus.cache_size_o      = lat_size;

  // Read data is passed through only on the writeback cycle
  assign bus.wb_valid_o        = ld_done;
  assign bus.wb_ticket_o       = lat_ticket;
  assign bus.wb_microop_o      = lat_microop;
  assign bus.wb_data_o         = ld_done ? bus.cache_rdata_i : '0;

endmodule
